key_irq_servicer: RTL
=====================

Name: key_irq_servicer

Overview:
Avalon-MM master that sequences the single-bit key PIO slave (data at address 0, irq_mask at 2, edge_capture at 3).
- At start-up, programs irq_mask.
- On irq, reads edge_capture, clears it, then samples the key level.
- Emits one key event on a valid/ready stream, then enforces a debounce hold-off window before re-arming.
- Sits between the key PIO and LED/control logic, so software polling is not needed.

Parameters:
HOLDOFF_CYC, 500000, lockout cycles after each emitted event (debounce); minimum 1
CNT_W, 16, width of the event counter

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
en  in  1  1 = servicing enabled (irq_mask=1); 0 = masked
avm_address  out  2  PIO register address
avm_chipselect  out  1  PIO select, one cycle per access
avm_write_n  out  1  active-low write strobe
avm_writedata  out  32  write data
avm_readdata  in  32  PIO read data, valid exactly 1 cycle after the access cycle
pio_irq  in  1  PIO interrupt (edge_capture & irq_mask)
evt_valid  out  1  key event available
evt_ready  in  1  consumer accepts event
evt_level  out  1  key level sampled after the edge (readdata[0] of address 0)
evt_count  out  CNT_W  number of events accepted since reset
busy  out  1  1 in every state except WAIT_IRQ

Behaviour:
- Single clock. Reset is synchronous and active-high: reset sampled high at a clk edge forces the following register values on that edge. Reset overrides any state, including mid-access.
- Reset values:
  - state = INIT_MASK
  - avm_chipselect = 0, avm_write_n = 1, avm_address = 0, avm_writedata = 0
  - evt_valid = 0, evt_level = 0, evt_count = 0, busy = 1
- Bus rules:
  - An access is exactly one cycle with avm_chipselect = 1.
  - Write cycle: avm_write_n = 0. Read cycle: avm_write_n = 1.
  - All bus outputs are registered. chipselect is 0 in every non-access cycle.
  - Read data is sampled in the cycle after the read access (the _WT state).
  - No wait-request; every access completes in one cycle.
- FSM states and transitions:
  - INIT_MASK: write address 2, writedata = {31'b0, en}; latch en_q = en; -> WAIT_IRQ.
  - WAIT_IRQ: busy = 0.
    - If en != en_q: -> INIT_MASK.
    - Else if pio_irq and en_q: -> RD_CAP.
    - Else stay.
  - RD_CAP: read address 3; -> RD_CAP_WT.
  - RD_CAP_WT: sample readdata[0].
    - If 0 (spurious or already cleared): -> WAIT_IRQ.
    - Else: -> CLR_CAP.
  - CLR_CAP: write address 3, writedata = 32'h1; -> RD_DAT.
  - RD_DAT: read address 0; -> RD_DAT_WT.
  - RD_DAT_WT: evt_level <= readdata[0]; -> EMIT.
  - EMIT: evt_valid = 1.
    - Exit only on evt_valid & evt_ready. That cycle: evt_count += 1 (wraps modulo 2^CNT_W) and load hold-off counter = HOLDOFF_CYC-1; -> HOLDOFF.
    - evt_level is stable while evt_valid = 1.
  - HOLDOFF: decrement the counter each cycle; at 0 -> INIT_MASK. Re-writing the mask picks up any en change.
- Edges captured by the PIO during CLR_CAP..HOLDOFF:
  - An edge that lands on the same cycle as the clear is lost. This is accepted behaviour.
  - An edge after the clear keeps pio_irq high and is serviced after HOLDOFF. This gives at most one event per hold-off window.
- en is ignored outside WAIT_IRQ and INIT_MASK. Deasserting en during EMIT does not withdraw evt_valid.
- Minimum service latency from pio_irq high in WAIT_IRQ to evt_valid = 1 is 6 cycles.
- pio_irq is not re-checked after RD_CAP. The edge_capture read is authoritative.

Decomposition:
- Shared package key_pio_pkg:
  - register address constants ADDR_DATA = 0, ADDR_MASK = 2, ADDR_EDGE = 3
  - state enum type for the FSM
  - CLR_WORD = 32'h1
- One sub-module, holdoff_timer: loadable down-counter sized clog2(HOLDOFF_CYC), with load, en and zero outputs.
- FSM and bus registers stay in the top.

Test Plan:
- Reset then en = 1, with a PIO model attached. Required: first access after reset release is a write to addr 2, data 1; busy drops one cycle later; mask register in the model = 1.
- Key rising edge, evt_ready tied 1, key held high. Required bus sequence: read 3, write 3 data 1, read 0. Then evt_valid = 1 with evt_level = 1, 6 cycles after irq; evt_count 0 -> 1; model edge_capture = 0.
- HOLDOFF_CYC = 8; a second edge 3 cycles after evt accept. Required: no bus access during hold-off; the second event is emitted after hold-off + mask rewrite; evt_count = 2.
- Force pio_irq high with model edge_capture = 0. Required: read 3 only, no clear write, return to WAIT_IRQ, no event.
- evt_ready held 0 for 20 cycles during EMIT. Required: evt_valid and evt_level stable, no bus accesses; count increments only on the accept cycle.
- Toggle en 1 -> 0 in WAIT_IRQ, then assert reset mid-RD_DAT_WT and check after reset.
  - After en -> 0: write addr 2, data 0, and no servicing on later edges.
  - After reset: all outputs at reset values, and the next access is the mask write.

Source files
------------

// File: rtl/key_pio_pkg.sv
// Shared definitions for the key PIO servicer: register map, clear word and FSM state type.
package key_pio_pkg;

   localparam logic [1:0]  ADDR_DATA = 2'd0;
   localparam logic [1:0]  ADDR_MASK = 2'd2;
   localparam logic [1:0]  ADDR_EDGE = 2'd3;
   localparam logic [31:0] CLR_WORD  = 32'h1;

   typedef enum logic [3:0] {
      ST_INIT_MASK,
      ST_WAIT_IRQ,
      ST_RD_CAP,
      ST_RD_CAP_WT,
      ST_CLR_CAP,
      ST_RD_DAT,
      ST_RD_DAT_WT,
      ST_EMIT,
      ST_HOLDOFF
   } state_e;

endpackage

// File: rtl/key_irq_servicer_holdoff_timer.sv
// Loadable down-counter for the debounce lockout; load_i presets HOLDOFF_CYC-1, en_i decrements.
module holdoff_timer #(
   parameter int HOLDOFF_CYC = 500000
) (
   input  logic clk,
   input  logic reset,
   input  logic load_i,
   input  logic en_i,
   output logic zero_o
);

   localparam int W = (HOLDOFF_CYC > 1) ? $clog2(HOLDOFF_CYC) : 1;
   localparam logic [W-1:0] LOAD_VAL = W'(HOLDOFF_CYC - 1);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else if (load_i) begin
         cnt_q <= LOAD_VAL;
      end else if (en_i && (cnt_q != '0)) begin
         cnt_q <= cnt_q - W'(1);
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/key_irq_servicer.sv
// Avalon-MM master that services the key PIO interrupt and emits debounced key events.
//
// state        | meaning
// INIT_MASK    | first cycle arms the irq_mask write, second cycle presents it
// WAIT_IRQ     | idle, watching pio_irq and en changes
// RD_CAP       | read access to edge_capture
// RD_CAP_WT    | edge_capture data returns; zero means spurious
// CLR_CAP      | write access clearing edge_capture
// RD_DAT       | read access to the key data register
// RD_DAT_WT    | key level returns and is latched
// EMIT         | evt_valid held until accepted
// HOLDOFF      | debounce lockout, then re-arm through INIT_MASK
module key_irq_servicer
   import key_pio_pkg::*;
#(
   parameter int HOLDOFF_CYC = 500000,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   output logic [1:0]       avm_address,
   output logic             avm_chipselect,
   output logic             avm_write_n,
   output logic [31:0]      avm_writedata,
   input  logic [31:0]      avm_readdata,
   input  logic             pio_irq,
   output logic             evt_valid,
   input  logic             evt_ready,
   output logic             evt_level,
   output logic [CNT_W-1:0] evt_count,
   output logic             busy
);

   state_e           state_q;
   logic             en_q;
   logic             cs_q;
   logic             write_n_q;
   logic [1:0]       addr_q;
   logic [31:0]      wdata_q;
   logic             evt_valid_q;
   logic             evt_level_q;
   logic [CNT_W-1:0] evt_count_q;
   logic             busy_q;

   logic tmr_load;
   logic tmr_dec;
   logic tmr_zero;
   logic unused_rd;

   assign unused_rd = ^avm_readdata[31:1];

   assign tmr_load = (state_q == ST_EMIT) && evt_valid_q && evt_ready;
   assign tmr_dec  = (state_q == ST_HOLDOFF);

   holdoff_timer #(
      .HOLDOFF_CYC (HOLDOFF_CYC)
   ) u_holdoff (
      .clk    (clk),
      .reset  (reset),
      .load_i (tmr_load),
      .en_i   (tmr_dec),
      .zero_o (tmr_zero)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_INIT_MASK;
         en_q        <= 1'b0;
         cs_q        <= 1'b0;
         write_n_q   <= 1'b1;
         addr_q      <= 2'd0;
         wdata_q     <= 32'd0;
         evt_valid_q <= 1'b0;
         evt_level_q <= 1'b0;
         evt_count_q <= '0;
         busy_q      <= 1'b1;
      end else begin
         // Bus strobes default to idle so every access lasts exactly one cycle.
         cs_q      <= 1'b0;
         write_n_q <= 1'b1;
         case (state_q)
            ST_INIT_MASK: begin
               if (!cs_q) begin
                  cs_q      <= 1'b1;
                  write_n_q <= 1'b0;
                  addr_q    <= ADDR_MASK;
                  wdata_q   <= {31'd0, en};
                  en_q      <= en;
               end else begin
                  busy_q  <= 1'b0;
                  state_q <= ST_WAIT_IRQ;
               end
            end
            ST_WAIT_IRQ: begin
               if (en != en_q) begin
                  busy_q  <= 1'b1;
                  state_q <= ST_INIT_MASK;
               end else if (pio_irq && en_q) begin
                  busy_q  <= 1'b1;
                  cs_q    <= 1'b1;
                  addr_q  <= ADDR_EDGE;
                  state_q <= ST_RD_CAP;
               end
            end
            ST_RD_CAP: state_q <= ST_RD_CAP_WT;
            ST_RD_CAP_WT: begin
               if (avm_readdata[0]) begin
                  cs_q      <= 1'b1;
                  write_n_q <= 1'b0;
                  addr_q    <= ADDR_EDGE;
                  wdata_q   <= CLR_WORD;
                  state_q   <= ST_CLR_CAP;
               end else begin
                  busy_q  <= 1'b0;
                  state_q <= ST_WAIT_IRQ;
               end
            end
            ST_CLR_CAP: begin
               cs_q    <= 1'b1;
               addr_q  <= ADDR_DATA;
               state_q <= ST_RD_DAT;
            end
            ST_RD_DAT: state_q <= ST_RD_DAT_WT;
            ST_RD_DAT_WT: begin
               evt_level_q <= avm_readdata[0];
               evt_valid_q <= 1'b1;
               state_q     <= ST_EMIT;
            end
            ST_EMIT: begin
               if (evt_valid_q && evt_ready) begin
                  evt_valid_q <= 1'b0;
                  evt_count_q <= evt_count_q + CNT_W'(1);
                  state_q     <= ST_HOLDOFF;
               end
            end
            ST_HOLDOFF: begin
               if (tmr_zero) state_q <= ST_INIT_MASK;
            end
            default: begin
               busy_q  <= 1'b1;
               state_q <= ST_INIT_MASK;
            end
         endcase
      end
   end

   assign avm_address    = addr_q;
   assign avm_chipselect = cs_q;
   assign avm_write_n    = write_n_q;
   assign avm_writedata  = wdata_q;
   assign evt_valid      = evt_valid_q;
   assign evt_level      = evt_level_q;
   assign evt_count      = evt_count_q;
   assign busy           = busy_q;

endmodule
